// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite compositor.
//   rgb_t       24-bit packed colour {r, g, b}
//   SCREEN_W/H  active display size in pixels / lines
//   TRANSP_KEY  default colour key that marks a sprite texel as see-through
//   spr_aw()    sprite ROM address width = frame bits + log2(SPR_W*SPR_H)
// -----------------------------------------------------------------------------
package sprite_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [23:0] TRANSP_KEY = 24'hFF00FF;

  function automatic int spr_aw(input int frame_w, input int spr_w, input int spr_h);
    return frame_w + $clog2(spr_w * spr_h);
  endfunction

endpackage

// File: rtl/sprite_fetch.sv
// -----------------------------------------------------------------------------
// sprite_fetch
// First pipeline stage for one sprite layer: decides whether the current
// pixel falls inside the sprite box and builds the sprite ROM address
// {frame, row, col}. Both results are registered; they hold while
// i_pix_valid is low so the ROM keeps reading a stable address.
//
// Build option: SPRITE_MIRROR_EN - when defined, i_mirror flips the column
// (col = SPR_W-1-dx). When undefined, i_mirror is ignored and col = dx.
// Latency is the same either way.
//
// Ports
//   i_clk, i_srst        clock, synchronous active-high reset
//   i_pix_valid          current DrawX/DrawY is an active pixel
//   i_draw_x, i_draw_y   current pixel position
//   i_spr_x, i_spr_y     sprite top-left corner
//   i_en                 sprite enable
//   i_frame              animation frame select
//   i_mirror             horizontal mirror request
//   o_in_box             registered "pixel lies inside enabled sprite"
//   o_rom_addr           registered sprite ROM address
// -----------------------------------------------------------------------------
module sprite_fetch #(
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int FRAME_W = 2,
  parameter int SPR_AW  = sprite_pkg::spr_aw(FRAME_W, SPR_W, SPR_H)
) (
  input  logic               i_clk,
  input  logic               i_srst,
  input  logic               i_pix_valid,
  input  logic [9:0]         i_draw_x,
  input  logic [9:0]         i_draw_y,
  input  logic [9:0]         i_spr_x,
  input  logic [9:0]         i_spr_y,
  input  logic               i_en,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_mirror,
  output logic               o_in_box,
  output logic [SPR_AW-1:0]  o_rom_addr
);
  import sprite_pkg::*;

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  localparam logic [9:0]       SPR_W_L = 10'(SPR_W);
  localparam logic [9:0]       SPR_H_L = 10'(SPR_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPR_W - 1);

  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic              w_in_box;
  logic [COL_W-1:0]  w_col;
  logic [SPR_AW-1:0] w_addr;

  logic              r_in_box;
  logic [SPR_AW-1:0] r_rom_addr;

  // 11-bit subtraction: bit 10 is the borrow, set whenever the pixel lies
  // left of / above the sprite origin. A sprite parked at e.g. x=1020 is
  // therefore never visible at small DrawX, instead of wrapping round.
  assign w_dx = {1'b0, i_draw_x} - {1'b0, i_spr_x};
  assign w_dy = {1'b0, i_draw_y} - {1'b0, i_spr_y};

  assign w_in_box = i_en && !w_dx[10] && !w_dy[10]
                    && (w_dx[9:0] < SPR_W_L) && (w_dy[9:0] < SPR_H_L);

`ifdef SPRITE_MIRROR_EN
  assign w_col = i_mirror ? (COL_MAX - w_dx[COL_W-1:0]) : w_dx[COL_W-1:0];
`else
  logic w_mirror_unused;
  assign w_mirror_unused = i_mirror;
  assign w_col = w_dx[COL_W-1:0];
`endif

  assign w_addr = {i_frame, w_dy[ROW_W-1:0], w_col};

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_in_box   <= 1'b0;
      r_rom_addr <= '0;
    end else if (i_pix_valid) begin
      r_in_box   <= w_in_box;
      r_rom_addr <= w_addr;
    end
  end

  assign o_in_box   = r_in_box;
  assign o_rom_addr = r_rom_addr;

endmodule

// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
// Composites N_SPR sprite layers over the maze background for every VGA
// pixel, with a fixed 3-edge latency:
//   edge 1  per-sprite box test + ROM addresses (sprite_fetch), maze address
//   edge 2  external synchronous ROMs present data; flags travel alongside
//   edge 3  colour-key test, priority mux (index 0 wins), RGB register,
//           collision flag update
// Sprite 0 is Pac-Man; a frame in which it overlaps sprite i with both
// texels opaque raises coll_flags[i] for the whole following frame.
//
// Build option: SPRITE_MIRROR_EN - enables horizontal mirroring through
// spr_mirror (handled in sprite_fetch). Undefined: spr_mirror is ignored.
//
// Ports
//   Clk, Reset           clock, synchronous active-high reset
//   frame_start          one-cycle pulse at start of each frame
//   pix_valid_in         DrawX/DrawY is an active pixel
//   DrawX, DrawY         pixel column / row
//   spr_x, spr_y         packed sprite top-left positions (10 bits each)
//   spr_en, spr_mirror   per-sprite enable / mirror request
//   spr_frame            packed per-sprite animation frame
//   spr_rom_addr         packed sprite ROM addresses
//   spr_rom_data         packed sprite ROM data (1-cycle read latency)
//   maze_rom_addr/data   background ROM address / data (1-cycle latency)
//   VGA_R/G/B            composited colour, 0 for inactive pixels
//   pix_valid_out        output pixel valid
//   coll_flags           collision snapshot of previous frame, bit 0 = 0
// -----------------------------------------------------------------------------
module sprite_compositor #(
  parameter int          N_SPR      = 4,
  parameter int          SPR_W      = 16,
  parameter int          SPR_H      = 16,
  parameter int          FRAME_W    = 2,
  parameter int          SCREEN_W   = sprite_pkg::SCREEN_W,
  parameter logic [23:0] TRANSP_KEY = sprite_pkg::TRANSP_KEY
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic                       pix_valid_in,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic [N_SPR*10-1:0]        spr_x,
  input  logic [N_SPR*10-1:0]        spr_y,
  input  logic [N_SPR-1:0]           spr_en,
  input  logic [N_SPR*FRAME_W-1:0]   spr_frame,
  input  logic [N_SPR-1:0]           spr_mirror,
  output logic [N_SPR*sprite_pkg::spr_aw(FRAME_W, SPR_W, SPR_H)-1:0] spr_rom_addr,
  input  logic [N_SPR*24-1:0]        spr_rom_data,
  output logic [18:0]                maze_rom_addr,
  input  logic [23:0]                maze_rom_data,
  output logic [7:0]                 VGA_R,
  output logic [7:0]                 VGA_G,
  output logic [7:0]                 VGA_B,
  output logic                       pix_valid_out,
  output logic [N_SPR-1:0]           coll_flags
);
  import sprite_pkg::*;

  localparam int SPR_AW = spr_aw(FRAME_W, SPR_W, SPR_H);

  // ---------------------------------------------------------------- stage 1
  logic [N_SPR-1:0] w_in_box_s1;
  logic [18:0]      w_maze_addr;
  logic [18:0]      r_maze_addr;
  logic             r_valid_s1;

  genvar gi;
  generate
    for (gi = 0; gi < N_SPR; gi++) begin : g_fetch
      sprite_fetch #(
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .FRAME_W (FRAME_W),
        .SPR_AW  (SPR_AW)
      ) u_fetch (
        .i_clk       (Clk),
        .i_srst      (Reset),
        .i_pix_valid (pix_valid_in),
        .i_draw_x    (DrawX),
        .i_draw_y    (DrawY),
        .i_spr_x     (spr_x[10*gi +: 10]),
        .i_spr_y     (spr_y[10*gi +: 10]),
        .i_en        (spr_en[gi]),
        .i_frame     (spr_frame[FRAME_W*gi +: FRAME_W]),
        .i_mirror    (spr_mirror[gi]),
        .o_in_box    (w_in_box_s1[gi]),
        .o_rom_addr  (spr_rom_addr[SPR_AW*gi +: SPR_AW])
      );
    end
  endgenerate

  assign w_maze_addr = 19'(DrawX) + 19'(DrawY) * 19'(SCREEN_W);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid_s1  <= 1'b0;
      r_maze_addr <= '0;
    end else begin
      r_valid_s1 <= pix_valid_in;
      // Hold the address on blank pixels so the ROM is not toggled needlessly.
      if (pix_valid_in) begin
        r_maze_addr <= w_maze_addr;
      end
    end
  end

  assign maze_rom_addr = r_maze_addr;

  // ---------------------------------------------------------------- stage 2
  // The external ROMs register their output on this edge, so the data needs
  // no local register; only the stage-1 flags are carried along with it.
  logic             r_valid_s2;
  logic [N_SPR-1:0] r_in_box_s2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid_s2  <= 1'b0;
      r_in_box_s2 <= '0;
    end else begin
      r_valid_s2  <= r_valid_s1;
      r_in_box_s2 <= w_in_box_s1;
    end
  end

  // ---------------------------------------------------------------- stage 3
  rgb_t             w_spr_rgb [N_SPR];
  logic [N_SPR-1:0] w_hit;
  logic [N_SPR-1:0] w_coll_new;
  rgb_t             w_pix;

  generate
    for (gi = 0; gi < N_SPR; gi++) begin : g_hit
      assign w_spr_rgb[gi] = rgb_t'(spr_rom_data[24*gi +: 24]);
      assign w_hit[gi]     = r_in_box_s2[gi] && (spr_rom_data[24*gi +: 24] != TRANSP_KEY);
    end
  endgenerate

  // Walk from lowest to highest priority so the lowest-index hit lands last.
  always_comb begin
    w_pix = rgb_t'(maze_rom_data);
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_pix = w_spr_rgb[i];
      end
    end
  end

  // Sprite 0 never collides with itself.
  assign w_coll_new[0] = 1'b0;
  generate
    for (gi = 1; gi < N_SPR; gi++) begin : g_coll
      assign w_coll_new[gi] = r_valid_s2 && w_hit[0] && w_hit[gi];
    end
  endgenerate

  rgb_t             r_rgb;
  logic             r_pix_valid;
  logic [N_SPR-1:0] r_coll_live;
  logic [N_SPR-1:0] r_coll_snap;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rgb       <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_valid <= r_valid_s2;
      r_rgb       <= r_valid_s2 ? w_pix : '0;
    end
  end

  // A hit seen on the same edge as frame_start belongs to the new frame:
  // it seeds the freshly cleared live set rather than the snapshot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_coll_live <= '0;
      r_coll_snap <= '0;
    end else if (frame_start) begin
      r_coll_snap <= r_coll_live;
      r_coll_live <= w_coll_new;
    end else begin
      r_coll_live <= r_coll_live | w_coll_new;
    end
  end

  assign VGA_R         = r_rgb.r;
  assign VGA_G         = r_rgb.g;
  assign VGA_B         = r_rgb.b;
  assign pix_valid_out = r_pix_valid;
  assign coll_flags    = r_coll_snap;

endmodule

// File: tb/tb_sprite_compositor.sv
// -----------------------------------------------------------------------------
// tb_sprite_compositor
// Directed bench for sprite_compositor with its default parameters. Sprite
// ROMs return a per-sprite colour held in spr_color; the maze ROM returns its
// own address as colour so background pixels are easy to predict by hand.
// Both ROM models have one cycle of read latency.
// -----------------------------------------------------------------------------
module tb_sprite_compositor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        pix_valid_in;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [39:0] spr_x;
  logic [39:0] spr_y;
  logic [3:0]  spr_en;
  logic [7:0]  spr_frame;
  logic [3:0]  spr_mirror;
  logic [39:0] spr_rom_addr;
  logic [95:0] spr_rom_data;
  logic [18:0] maze_rom_addr;
  logic [23:0] maze_rom_data;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        pix_valid_out;
  logic [3:0]  coll_flags;

  logic [23:0] spr_color [4];
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef SPRITE_MIRROR_EN
  localparam logic [9:0] MIRROR_COL = 10'd15;
`else
  localparam logic [9:0] MIRROR_COL = 10'd0;
`endif

  sprite_compositor dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_start   (frame_start),
    .pix_valid_in  (pix_valid_in),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .spr_x         (spr_x),
    .spr_y         (spr_y),
    .spr_en        (spr_en),
    .spr_frame     (spr_frame),
    .spr_mirror    (spr_mirror),
    .spr_rom_addr  (spr_rom_addr),
    .spr_rom_data  (spr_rom_data),
    .maze_rom_addr (maze_rom_addr),
    .maze_rom_data (maze_rom_data),
    .VGA_R         (VGA_R),
    .VGA_G         (VGA_G),
    .VGA_B         (VGA_B),
    .pix_valid_out (pix_valid_out),
    .coll_flags    (coll_flags)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM models
  always @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      spr_rom_data[24*i +: 24] <= spr_color[i];
    end
    maze_rom_data <= {5'd0, maze_rom_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic en, input logic [23:0] col,
                         input logic [1:0] fr, input logic mir);
    spr_x[10*i +: 10]   = x;
    spr_y[10*i +: 10]   = y;
    spr_en[i]           = en;
    spr_color[i]        = col;
    spr_frame[2*i +: 2] = fr;
    spr_mirror[i]       = mir;
  endtask

  // Present one valid pixel for exactly one edge; returns just after edge 1.
  task automatic launch(input logic [9:0] x, input logic [9:0] y);
    @(negedge Clk);
    DrawX        = x;
    DrawY        = y;
    pix_valid_in = 1'b1;
    @(posedge Clk); #1;
    pix_valid_in = 1'b0;
  endtask

  // Waits edges 2 and 3 and checks the composited pixel.
  task automatic finish_px(input string tag, input logic [23:0] exp);
    repeat (2) @(posedge Clk);
    #1;
    $display("pixel %s: rgb=%02h%02h%02h valid=%0d", tag, VGA_R, VGA_G, VGA_B, pix_valid_out);
    chk({tag, " valid"}, 32'(pix_valid_out), 32'd1);
    chk({tag, " rgb"}, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp});
  endtask

  task automatic frame_pulse();
    @(negedge Clk);
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    $display("frame_start: coll_flags=%04b", coll_flags);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b1;
    frame_start  = 1'b0;
    pix_valid_in = 1'b0;
    DrawX        = '0;
    DrawY        = '0;
    spr_x        = '0;
    spr_y        = '0;
    spr_en       = '0;
    spr_frame    = '0;
    spr_mirror   = '0;
    for (int i = 0; i < 4; i++) spr_color[i] = 24'h000000;

    // ---- reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst valid", 32'(pix_valid_out), 32'd0);
    chk("rst rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("rst coll", 32'(coll_flags), 32'd0);
    chk("rst spr_addr zero", 32'(spr_rom_addr === 40'd0), 32'd1);
    chk("rst maze_addr", 32'(maze_rom_addr), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // ---- single sprite at (100,50), frame 2, green
    set_spr(1, 10'd100, 10'd50, 1'b1, 24'h00FF00, 2'd2, 1'b0);
    launch(10'd105, 10'd55);
    chk("spr1 rom addr", 32'(spr_rom_addr[19:10]), 32'h255);
    chk("maze addr", 32'(maze_rom_addr), 32'd35305);
    @(posedge Clk); #1;
    chk("latency edge2 valid", 32'(pix_valid_out), 32'd0);
    @(posedge Clk); #1;
    chk("latency edge3 valid", 32'(pix_valid_out), 32'd1);
    chk("spr1 green rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0000FF00);
    @(posedge Clk); #1;
    chk("bubble valid", 32'(pix_valid_out), 32'd0);
    chk("bubble rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    launch(10'd99, 10'd55);
    finish_px("spr1 left of box", 24'h0089E3);

    // ---- priority and colour key: sprites 0 and 2 at (200,200)
    set_spr(1, 10'd0, 10'd0, 1'b0, 24'h000000, 2'd0, 1'b0);
    set_spr(0, 10'd200, 10'd200, 1'b1, 24'hFF00FF, 2'd0, 1'b0);
    set_spr(2, 10'd200, 10'd200, 1'b1, 24'hFF0000, 2'd0, 1'b0);
    launch(10'd203, 10'd207);
    finish_px("key shows spr2", 24'hFF0000);
    spr_color[0] = 24'hFFFF00;
    launch(10'd203, 10'd207);
    finish_px("spr0 on top", 24'hFFFF00);
    frame_pulse();
    chk("coll snap spr2", 32'(coll_flags), 32'b0100);

    // ---- collision between sprites 0 and 3
    set_spr(2, 10'd0, 10'd0, 1'b0, 24'h000000, 2'd0, 1'b0);
    set_spr(3, 10'd200, 10'd200, 1'b1, 24'h0000FF, 2'd0, 1'b0);
    launch(10'd210, 10'd215);
    finish_px("spr0 over spr3", 24'hFFFF00);
    chk("coll snap held", 32'(coll_flags), 32'b0100);
    frame_pulse();
    chk("coll snap spr3", 32'(coll_flags), 32'b1000);
    frame_pulse();
    chk("coll cleared", 32'(coll_flags), 32'b0000);

    // hit evaluated on the frame_start edge lands in the new frame
    launch(10'd210, 10'd215);
    @(posedge Clk); #1;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    chk("coll same-edge snap", 32'(coll_flags), 32'b0000);
    frame_pulse();
    chk("coll same-edge live", 32'(coll_flags), 32'b1000);

    // ---- right edge and off-left sprites
    set_spr(0, 10'd0, 10'd0, 1'b0, 24'h000000, 2'd0, 1'b0);
    set_spr(3, 10'd0, 10'd0, 1'b0, 24'h000000, 2'd0, 1'b0);
    set_spr(1, 10'd630, 10'd0, 1'b1, 24'h00FF00, 2'd0, 1'b0);
    launch(10'd639, 10'd3);
    finish_px("x630 col639", 24'h00FF00);
    launch(10'd629, 10'd3);
    finish_px("x630 col629", 24'h0009F5);
    launch(10'd0, 10'd3);
    finish_px("x630 no wrap", 24'h000780);
    set_spr(1, 10'd1020, 10'd0, 1'b1, 24'h00FF00, 2'd0, 1'b0);
    launch(10'd0, 10'd3);
    finish_px("x1020 col0", 24'h000780);
    launch(10'd3, 10'd3);
    finish_px("x1020 col3", 24'h000783);

    // ---- invalid pixel: addresses hold, output blank
    @(negedge Clk);
    DrawX        = 10'd100;
    DrawY        = 10'd100;
    pix_valid_in = 1'b0;
    @(posedge Clk); #1;
    chk("invalid maze hold", 32'(maze_rom_addr), 32'd1923);
    repeat (2) @(posedge Clk);
    #1;
    chk("invalid valid", 32'(pix_valid_out), 32'd0);
    chk("invalid rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);

    // ---- mirror column
    set_spr(1, 10'd0, 10'd0, 1'b1, 24'h00FF00, 2'd0, 1'b1);
    launch(10'd0, 10'd0);
    chk("mirror col", 32'(spr_rom_addr[19:10]), 32'(MIRROR_COL));
    repeat (2) @(posedge Clk);
    #1;
    chk("mirror rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0000FF00);

    // ---- reset mid-frame with pixels in flight
    set_spr(1, 10'd0, 10'd0, 1'b0, 24'h000000, 2'd0, 1'b0);
    set_spr(0, 10'd300, 10'd300, 1'b1, 24'hFFFF00, 2'd0, 1'b0);
    set_spr(3, 10'd300, 10'd300, 1'b1, 24'h0000FF, 2'd0, 1'b0);
    launch(10'd305, 10'd305);
    finish_px("pre-reset overlap", 24'hFFFF00);
    frame_pulse();
    chk("pre-reset coll", 32'(coll_flags), 32'b1000);
    @(negedge Clk);
    DrawX        = 10'd305;
    DrawY        = 10'd305;
    pix_valid_in = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid-reset valid c%0d", k), 32'(pix_valid_out), 32'd0);
      chk($sformatf("mid-reset rgb c%0d", k), {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
      chk($sformatf("mid-reset coll c%0d", k), 32'(coll_flags), 32'd0);
      if (k < 2) begin
        @(posedge Clk); #1;
      end
    end
    pix_valid_in = 1'b0;
    repeat (3) @(posedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
